timer_countdown: RTL and testbench
==================================

TIMER_COUNTDOWN -- requirements
Module: timer_countdown

Interface
- REQ-001 Parameter ALARM_CYCLES, default 16: number of sys_clk cycles alarm stays high; legal range 1..255.
- REQ-002 sys_clk  input  1  system clock; all logic on its rising edge.
- REQ-003 int_reset_b  input  1  asynchronous, active-low reset.
- REQ-004 timer_clk  input  1  divided timer clock from the clock generator; sampled as data in sys_clk domain, never used as a clock.
- REQ-005 load  input  1  one-cycle pulse; latch preset and return to IDLE.
- REQ-006 start  input  1  one-cycle pulse; begin or resume countdown.
- REQ-007 pause  input  1  one-cycle pulse; suspend countdown.
- REQ-008 preset_min  input  8  two BCD digits, minutes 00..59.
- REQ-009 preset_sec  input  8  two BCD digits, seconds 00..59.
- REQ-010 cur_min  output  8  current BCD minutes.
- REQ-011 cur_sec  output  8  current BCD seconds.
- REQ-012 state  output  2  current FSM state encoding.
- REQ-013 alarm  output  1  high while expiry alarm active.
- REQ-014 load_err  output  1  one-cycle pulse on rejected preset.

Function
- REQ-015 Tick = timer_clk high AND registered previous timer_clk low; tick asserted the cycle after timer_clk rising edge is sampled; no synchronizer.
- REQ-016 States: IDLE=0, RUN=1, PAUSE=2, ALARM=3.
- REQ-017 Input priority within one cycle: load > start > pause; lower-priority pulses in the same cycle ignored.
- REQ-018 load, any state: valid preset -> preset register and cur_* updated next cycle, state IDLE, alarm cleared, alarm counter cleared.
- REQ-019 Preset invalid when any digit >9 or either tens digit >5 -> load_err pulses next cycle, preset register, cur_*, state unchanged.
- REQ-020 start: IDLE or PAUSE with cur != 00:00 -> RUN; IDLE with cur = 00:00 -> stays IDLE; ignored in RUN and ALARM.
- REQ-021 pause: RUN -> PAUSE; ignored elsewhere; ticks ignored outside RUN.
- REQ-022 Tick in RUN: sec units decrement; units 0 -> units 9, sec tens decrement; sec 00 -> sec 59, minutes decrement BCD with same borrow rule.
- REQ-023 Tick in RUN at 00:01 -> cur 00:00 and, same edge, state ALARM, alarm high, alarm counter loaded with ALARM_CYCLES.
- REQ-024 ALARM: alarm counter decrements each cycle; alarm drops and state returns IDLE on the cycle counter reaches 0; alarm high exactly ALARM_CYCLES cycles.
- REQ-025 Tick coincident with load: load wins, tick discarded.

Reset
- REQ-026 int_reset_b low: state IDLE, cur_min/cur_sec 8'h00, preset register 00:00, alarm 0, load_err 0, alarm counter 0, previous-timer_clk register 0; effective immediately, mid-countdown included.
- REQ-027 First tick after reset release requires an observed low-to-high timer_clk transition after release.

Configuration
- REQ-028 Macro TIMER_AUTO_RELOAD_EN defined: at expiry cur_* reload from preset register, state stays RUN, alarm still pulses ALARM_CYCLES cycles via counter independent of state; ALARM state unreachable.
- REQ-029 Macro TIMER_AUTO_RELOAD_EN undefined: expiry behaves per REQ-023/REQ-024.

Structure
- REQ-030 Package timer_pkg: state enum typedef, BCD digit typedef (4 bits), MAX_TENS=5 and MAX_UNITS=9 constants.
- REQ-031 One sub-module timer_bcd_dec: combinational two-digit BCD decrement with tens limit input, borrow out; instantiated twice (seconds, minutes).

Verification
- REQ-032 load 01:05, start, timer_clk from divide-by-10 generator (tick every 20 sys_clk) -> cur 01:04, 01:03 ... 00:59 after 6 ticks; alarm after 65 ticks.
- REQ-033 load 00:02, start, 2 ticks -> alarm high exactly 16 cycles (default), then state IDLE, cur 00:00.
- REQ-034 load preset_sec 8'h6A -> load_err one cycle, cur_* and state unchanged.
- REQ-035 RUN at 00:30, pause, 5 ticks -> cur stays 00:30; start -> next tick 00:29.
- REQ-036 load, start and pause same cycle during RUN -> IDLE with new preset; reset asserted mid-RUN -> all outputs reset values immediately.
- REQ-037 TIMER_AUTO_RELOAD_EN build, preset 00:03, start -> after 3 ticks cur 00:03, state RUN, alarm 16 cycles.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared types and constants for the BCD countdown timer.
//   timer_state_e  : FSM encoding, also driven on the top-level `state` output
//   bcd_digit_t    : one packed BCD digit
//   MAX_TENS/UNITS : largest legal tens/units digit of a mm or ss field
//   bcd_pair_valid : true when an 8-bit two-digit BCD value lies in 00..59
package timer_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StAlarm = 2'd3
  } timer_state_e;

  typedef logic [3:0] bcd_digit_t;

  localparam bcd_digit_t MAX_TENS  = 4'd5;
  localparam bcd_digit_t MAX_UNITS = 4'd9;

  function automatic logic bcd_pair_valid(input logic [7:0] v);
    return (v[7:4] <= MAX_TENS) && (v[3:0] <= MAX_UNITS);
  endfunction

endpackage

// File: rtl/timer_bcd_dec.sv
// Combinational two-digit BCD decrement.
//   tens_i/units_i : current value
//   tens_max_i     : tens digit to wrap to when the value is 00
//   tens_o/units_o : value minus one (00 wraps to {tens_max_i, 9})
//   borrow_o       : high when the input was 00, i.e. the next field must decrement
module timer_bcd_dec
  import timer_pkg::*;
(
  input  bcd_digit_t tens_i,
  input  bcd_digit_t units_i,
  input  bcd_digit_t tens_max_i,
  output bcd_digit_t tens_o,
  output bcd_digit_t units_o,
  output logic       borrow_o
);

  always_comb begin
    tens_o   = tens_i;
    units_o  = units_i;
    borrow_o = 1'b0;
    if (units_i != 4'd0) begin
      units_o = units_i - 4'd1;
    end else begin
      units_o = MAX_UNITS;
      if (tens_i != 4'd0) begin
        tens_o = tens_i - 4'd1;
      end else begin
        tens_o   = tens_max_i;
        borrow_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/timer_countdown.sv
// mm:ss BCD countdown timer with expiry alarm.
//   sys_clk, int_reset_b : clock, asynchronous active-low reset
//   timer_clk            : divided clock, sampled as data; each rising edge is one second
//   load/start/pause     : one-cycle command pulses, priority load > start > pause
//   preset_min/sec       : BCD preset, latched on load when both fields are 00..59
//   cur_min/sec          : current BCD count
//   state                : timer_state_e encoding
//   alarm                : high for ALARM_CYCLES cycles after expiry
//   load_err             : one-cycle pulse when a load is rejected
// Build option: define TIMER_AUTO_RELOAD_EN to reload from the preset at expiry and keep running.
module timer_countdown
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_CYCLES = 16
) (
  input  logic       sys_clk,
  input  logic       int_reset_b,
  input  logic       timer_clk,
  input  logic       load,
  input  logic       start,
  input  logic       pause,
  input  logic [7:0] preset_min,
  input  logic [7:0] preset_sec,
  output logic [7:0] cur_min,
  output logic [7:0] cur_sec,
  output logic [1:0] state,
  output logic       alarm,
  output logic       load_err
);

  localparam logic [7:0] AlarmLoad = 8'(ALARM_CYCLES);

  timer_state_e state_q, state_d;
  logic [7:0]   min_q, min_d, sec_q, sec_d;
  logic [7:0]   alarm_cnt_q, alarm_cnt_d;
  logic         alarm_q, alarm_d;
  logic         load_err_q, load_err_d;
  logic         tclk_prev_q;

  logic         tick, preset_ok, cur_zero, expiring;
  bcd_digit_t   sec_tens_dec, sec_units_dec, min_tens_dec, min_units_dec;
  logic         sec_borrow, min_borrow;

  // timer_clk comes from a generator clocked by sys_clk, so no synchronizer.
  assign tick      = timer_clk & ~tclk_prev_q;
  assign preset_ok = bcd_pair_valid(preset_min) & bcd_pair_valid(preset_sec);
  // Both decrementers borrow only when their field is 00.
  assign cur_zero  = sec_borrow & min_borrow;
  assign expiring  = (min_q == 8'h00) && (sec_q == 8'h01);

  timer_bcd_dec u_sec_dec (
    .tens_i     (sec_q[7:4]),
    .units_i    (sec_q[3:0]),
    .tens_max_i (MAX_TENS),
    .tens_o     (sec_tens_dec),
    .units_o    (sec_units_dec),
    .borrow_o   (sec_borrow)
  );

  timer_bcd_dec u_min_dec (
    .tens_i     (min_q[7:4]),
    .units_i    (min_q[3:0]),
    .tens_max_i (MAX_TENS),
    .tens_o     (min_tens_dec),
    .units_o    (min_units_dec),
    .borrow_o   (min_borrow)
  );

`ifdef TIMER_AUTO_RELOAD_EN
  // Preset copy is only read back by the reload path.
  logic [7:0] pre_min_q, pre_sec_q;

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      pre_min_q <= 8'h00;
      pre_sec_q <= 8'h00;
    end else if (load && preset_ok) begin
      pre_min_q <= preset_min;
      pre_sec_q <= preset_sec;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    min_d       = min_q;
    sec_d       = sec_q;
    alarm_d     = alarm_q;
    alarm_cnt_d = alarm_cnt_q;
    load_err_d  = 1'b0;

    // Alarm countdown runs on its own; commands below may override it.
    if (alarm_q) begin
      alarm_cnt_d = alarm_cnt_q - 8'd1;
      if (alarm_cnt_d == 8'd0) begin
        alarm_d = 1'b0;
`ifndef TIMER_AUTO_RELOAD_EN
        state_d = StIdle;
`endif
      end
    end

    if (load) begin
      if (preset_ok) begin
        min_d       = preset_min;
        sec_d       = preset_sec;
        state_d     = StIdle;
        alarm_d     = 1'b0;
        alarm_cnt_d = 8'd0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (start) begin
      if ((state_q == StIdle || state_q == StPause) && !cur_zero) begin
        state_d = StRun;
      end
    end else if (pause) begin
      if (state_q == StRun) begin
        state_d = StPause;
      end
    end else if (tick && state_q == StRun) begin
      if (expiring) begin
`ifdef TIMER_AUTO_RELOAD_EN
        min_d   = pre_min_q;
        sec_d   = pre_sec_q;
`else
        min_d   = 8'h00;
        sec_d   = 8'h00;
        state_d = StAlarm;
`endif
        alarm_d     = 1'b1;
        alarm_cnt_d = AlarmLoad;
      end else begin
        sec_d = {sec_tens_dec, sec_units_dec};
        if (sec_borrow) begin
          min_d = {min_tens_dec, min_units_dec};
        end
      end
    end
  end

  always_ff @(posedge sys_clk or negedge int_reset_b) begin
    if (!int_reset_b) begin
      state_q     <= StIdle;
      min_q       <= 8'h00;
      sec_q       <= 8'h00;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= 8'd0;
      load_err_q  <= 1'b0;
      tclk_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      min_q       <= min_d;
      sec_q       <= sec_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
      load_err_q  <= load_err_d;
      tclk_prev_q <= timer_clk;
    end
  end

  assign cur_min  = min_q;
  assign cur_sec  = sec_q;
  assign state    = state_q;
  assign alarm    = alarm_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_timer_countdown.sv
`timescale 1ns/1ps
module tb_timer_countdown;

  localparam int unsigned AlarmCycles = 16;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit Auto = 1'b1;
`else
  localparam bit Auto = 1'b0;
`endif

  logic       sys_clk = 1'b0;
  logic       int_reset_b = 1'b1;
  logic       timer_clk = 1'b0;
  logic       load = 1'b0, start = 1'b0, pause = 1'b0;
  logic [7:0] preset_min = 8'h00, preset_sec = 8'h00;
  logic [7:0] cur_min, cur_sec;
  logic [1:0] state;
  logic       alarm, load_err;

  int total = 0;
  int bad = 0;
  int alarm_seen = 0;

  always #5 sys_clk = ~sys_clk;

  timer_countdown #(.ALARM_CYCLES(AlarmCycles)) dut (
    .sys_clk     (sys_clk),
    .int_reset_b (int_reset_b),
    .timer_clk   (timer_clk),
    .load        (load),
    .start       (start),
    .pause       (pause),
    .preset_min  (preset_min),
    .preset_sec  (preset_sec),
    .cur_min     (cur_min),
    .cur_sec     (cur_sec),
    .state       (state),
    .alarm       (alarm),
    .load_err    (load_err)
  );

  // Reference model: remaining time as plain seconds, alarm as cycles left.
  int m_rem, m_preset, m_state, m_alarm_left;
  bit m_load_err, m_prev_tc;

  function automatic bit bcd_ok(input logic [7:0] v);
    return (int'(v[7:4]) < 6) && (int'(v[3:0]) < 10);
  endfunction

  function automatic int bcd2int(input logic [7:0] v);
    return 10 * int'(v[7:4]) + int'(v[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int n);
    logic [7:0] r;
    r[7:4] = 4'(n / 10);
    r[3:0] = 4'(n % 10);
    return r;
  endfunction

  task automatic model_reset();
    m_rem = 0; m_preset = 0; m_state = 0; m_alarm_left = 0;
    m_load_err = 1'b0; m_prev_tc = 1'b0;
  endtask

  task automatic model_step(input logic ld, input logic st, input logic ps, input logic tc,
                            input logic [7:0] pm, input logic [7:0] psv);
    bit tk;
    tk = tc && !m_prev_tc;
    m_prev_tc = tc;
    m_load_err = 1'b0;
    if (m_alarm_left > 0) begin
      m_alarm_left--;
      if (m_alarm_left == 0 && !Auto) m_state = 0;
    end
    if (ld) begin
      if (bcd_ok(pm) && bcd_ok(psv)) begin
        m_preset = 60 * bcd2int(pm) + bcd2int(psv);
        m_rem = m_preset;
        m_state = 0;
        m_alarm_left = 0;
      end else begin
        m_load_err = 1'b1;
      end
    end else if (st) begin
      if ((m_state == 0 || m_state == 2) && m_rem != 0) m_state = 1;
    end else if (ps) begin
      if (m_state == 1) m_state = 2;
    end else if (tk && m_state == 1) begin
      m_rem--;
      if (m_rem == 0) begin
        if (Auto) m_rem = m_preset;
        else m_state = 3;
        m_alarm_left = AlarmCycles;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  task automatic check_model();
    chk("cur_min", 32'(cur_min), 32'(int2bcd(m_rem / 60)));
    chk("cur_sec", 32'(cur_sec), 32'(int2bcd(m_rem % 60)));
    chk("state", 32'(state), 32'(m_state));
    chk("alarm", 32'(alarm), 32'(m_alarm_left > 0));
    chk("load_err", 32'(load_err), 32'(m_load_err));
  endtask

  task automatic cycle(input logic ld, input logic st, input logic ps, input logic tc,
                       input logic [7:0] pm, input logic [7:0] psv);
    @(negedge sys_clk);
    load = ld; start = st; pause = ps; timer_clk = tc;
    preset_min = pm; preset_sec = psv;
    @(posedge sys_clk);
    model_step(ld, st, ps, tc, pm, psv);
    #1;
    check_model();
    if (alarm === 1'b1) alarm_seen++;
  endtask

  // One timer_clk period of the divide-by-10 generator: 10 low, 10 high.
  task automatic tick_periods(input int n);
    for (int i = 0; i < n; i++)
      for (int j = 0; j < 20; j++) cycle(1'b0, 1'b0, 1'b0, j >= 10, 8'h00, 8'h00);
  endtask

  task automatic quiet(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  task automatic expiry_run(input string nm, input logic [7:0] pm, input logic [7:0] psv,
                            input int nt);
    cycle(1'b1, 1'b0, 1'b0, 1'b0, pm, psv);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    alarm_seen = 0;
    tick_periods(nt);
    quiet(20);
    chk({nm, "_alarm_len"}, 32'(alarm_seen), AlarmCycles);
    chk({nm, "_state"}, 32'(state), Auto ? 32'd1 : 32'd0);
    chk({nm, "_min"}, 32'(cur_min), Auto ? 32'(pm) : 32'h00);
    chk({nm, "_sec"}, 32'(cur_sec), Auto ? 32'(psv) : 32'h00);
  endtask

  typedef struct {
    logic       ld, st, ps;
    logic [7:0] pm, psv;
    logic [7:0] e_min, e_sec;
    logic [1:0] e_state;
    logic       e_err;
  } vec_t;

  vec_t vecs[16];

  initial begin
    logic [7:0] rpm, rps;
    logic       tcl;
    int         r;

    vecs[0]  = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h05, 8'h01, 8'h05, 2'd0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, 8'h6A, 8'h01, 8'h05, 2'd0, 1'b1};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 8'h12, 8'h34, 8'h12, 8'h34, 2'd0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 8'h34, 2'd1, 1'b0};
    vecs[4]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 8'h34, 2'd1, 1'b0};
    vecs[5]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 8'h34, 2'd2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h12, 8'h34, 2'd2, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h12, 8'h34, 2'd1, 1'b0};
    vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 2'd0, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h60, 8'h00, 8'h00, 8'h00, 2'd0, 1'b1};
    vecs[11] = '{1'b1, 1'b0, 1'b0, 8'h59, 8'h59, 8'h59, 8'h59, 2'd0, 1'b0};
    vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h3A, 8'h00, 8'h59, 8'h59, 2'd0, 1'b1};
    vecs[13] = '{1'b0, 1'b0, 1'b1, 8'h00, 8'h00, 8'h59, 8'h59, 2'd0, 1'b0};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 8'h59, 8'h59, 2'd1, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b1, 8'h00, 8'h10, 8'h00, 8'h10, 2'd0, 1'b0};

    // Reset state
    #2 int_reset_b = 1'b0;
    #1;
    chk("rst_min", 32'(cur_min), 32'h00);
    chk("rst_sec", 32'(cur_sec), 32'h00);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_alarm", 32'(alarm), 32'd0);
    chk("rst_load_err", 32'(load_err), 32'd0);
    @(negedge sys_clk);
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    model_reset();

    // Table of single-cycle commands
    foreach (vecs[i]) begin
      cycle(vecs[i].ld, vecs[i].st, vecs[i].ps, 1'b0, vecs[i].pm, vecs[i].psv);
      chk($sformatf("vec%0d_min", i), 32'(cur_min), 32'(vecs[i].e_min));
      chk($sformatf("vec%0d_sec", i), 32'(cur_sec), 32'(vecs[i].e_sec));
      chk($sformatf("vec%0d_state", i), 32'(state), 32'(vecs[i].e_state));
      chk($sformatf("vec%0d_err", i), 32'(load_err), 32'(vecs[i].e_err));
    end

    // 01:05 counts through the minute boundary, then expires after 65 ticks
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h01, 8'h05);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick_periods(6);
    chk("m0105_min_6t", 32'(cur_min), 32'h00);
    chk("m0105_sec_6t", 32'(cur_sec), 32'h59);
    alarm_seen = 0;
    tick_periods(59);
    chk("m0105_alarm_on", 32'(alarm), 32'd1);
    quiet(20);
    chk("m0105_alarm_len", 32'(alarm_seen), AlarmCycles);
    chk("m0105_state", 32'(state), Auto ? 32'd1 : 32'd0);

    expiry_run("e0002", 8'h00, 8'h02, 2);
    expiry_run("e0003", 8'h00, 8'h03, 3);

    // Pause holds the count across ticks; start resumes
    cycle(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 8'h31);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick_periods(1);
    cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 8'h00);
    tick_periods(5);
    chk("pause_hold_sec", 32'(cur_sec), 32'h30);
    chk("pause_state", 32'(state), 32'd2);
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick_periods(1);
    chk("resume_sec", 32'(cur_sec), 32'h29);

    // All three pulses together mid-run: load wins
    cycle(1'b1, 1'b1, 1'b1, 1'b0, 8'h00, 8'h20);
    chk("lsp_state", 32'(state), 32'd0);
    chk("lsp_sec", 32'(cur_sec), 32'h20);

    // Reset mid-run takes effect without a clock edge
    cycle(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    tick_periods(1);
    @(negedge sys_clk);
    #2 int_reset_b = 1'b0;
    #1;
    chk("mid_rst_min", 32'(cur_min), 32'h00);
    chk("mid_rst_sec", 32'(cur_sec), 32'h00);
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_alarm", 32'(alarm), 32'd0);
    @(negedge sys_clk);
    timer_clk = 1'b1;
    @(negedge sys_clk);
    int_reset_b = 1'b1;
    model_reset();

    // timer_clk already high at release must not count as a tick
    cycle(1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 8'h05);
    cycle(1'b0, 1'b1, 1'b0, 1'b1, 8'h00, 8'h00);
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
    chk("no_tick_after_rst", 32'(cur_sec), 32'h05);

    // Random commands against the model
    tcl = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 4) == 0) tcl = ~tcl;
      if ($urandom_range(0, 9) < 7) begin
        rpm = int2bcd(int'($urandom_range(0, 1)));
        rps = int2bcd(int'($urandom_range(0, 20)));
      end else begin
        rpm = 8'($urandom_range(0, 255));
        rps = 8'($urandom_range(0, 255));
      end
      if (r < 1)       cycle(1'b1, 1'b1, 1'b1, tcl, rpm, rps);
      else if (r < 3)  cycle(1'b1, 1'b0, 1'b0, tcl, rpm, rps);
      else if (r < 8)  cycle(1'b0, 1'b1, 1'b0, tcl, rpm, rps);
      else if (r < 10) cycle(1'b0, 1'b0, 1'b1, tcl, rpm, rps);
      else if (r < 11) cycle(1'b0, 1'b1, 1'b1, tcl, rpm, rps);
      else             cycle(1'b0, 1'b0, 1'b0, tcl, rpm, rps);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
